pipeline_hazard_ctrl: RTL

//  Hazard and sequencing controller for the 5-stage ARM pipeline around the decode stage and its ID/EXE register.
//  - Shadows the dest/wb/mem fields of the instructions in EXE and MEM.
//  - Detects RAW hazards against the instruction in ID and stalls it.
//  - Flushes wrong-path instructions on a taken branch.
//  - Freezes the whole pipeline while a load/store waits on the multi-cycle data SRAM.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_mem_wait.sv | 64 ++++++
 rtl/pipeline_hazard_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller: register address
// width, memory-wait FSM state encoding and slot field widths.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDRESS_LEN = 4;

    // Slot flags: valid, wb_en, mem_read, mem_op
    localparam int unsigned SLOT_FLAG_W = 4;
    localparam int unsigned SLOT_W      = REG_ADDRESS_LEN + SLOT_FLAG_W;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait.sv
// Memory-wait sequencer: freezes the pipeline for MEM_WAIT_CYCLES cycles each
// time a load/store arrives in MEM, exactly once per memory op.
module mem_wait_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_CYCLES = 2,
    parameter int unsigned CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_op_in_mem,
    output logic freeze_all
);

    localparam bit              WAIT_EN  = (MEM_WAIT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_INIT = WAIT_EN ? CNT_W'(MEM_WAIT_CYCLES - 1) : '0;

    hz_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             served_q;
    logic             start_wait;

    // served_q blocks a second freeze for the op still sitting in MEM after its wait
    always_comb begin
        start_wait = 1'b0;
        freeze_all = 1'b0;
        start_wait = (state_q == HZ_RUN) & mem_op_in_mem & ~served_q & WAIT_EN;
        freeze_all = (state_q == HZ_WAIT) | start_wait;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HZ_RUN;
            cnt_q    <= '0;
            served_q <= 1'b0;
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (start_wait) begin
                        cnt_q <= CNT_INIT;
                        if (CNT_INIT != '0) begin
                            state_q <= HZ_WAIT;
                        end else begin
                            served_q <= 1'b1;
                        end
                    end else begin
                        served_q <= 1'b0;
                    end
                end
                HZ_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q  <= HZ_RUN;
                        served_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= HZ_RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: shadows EXE/MEM destination info, stalls ID
// on RAW hazards, flushes on taken branches and freezes on data-SRAM waits.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W      = REG_ADDRESS_LEN,
    parameter int unsigned MEM_WAIT_CYCLES = 2,
    parameter int unsigned CNT_W           = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_en,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic                  id_src1_used,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  exe_branch_taken,
    output logic                  hazard_stall,
    output logic                  flush_if_id,
    output logic                  flush_id_exe,
    output logic                  freeze_all
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
        logic                  mem_op;
    } slot_t;

    slot_t exe_q, exe_d;
    slot_t mem_q, mem_d;
    slot_t id_slot;

    logic hit1_exe, hit2_exe, hit1_mem, hit2_mem;
    logic hazard;
    logic flush;

    function automatic logic slot_hit(input slot_t s, input logic [REG_ADDR_W-1:0] src);
        return s.valid & s.wb_en & (s.dest == src);
    endfunction

    mem_wait_fsm #(
        .MEM_WAIT_CYCLES (MEM_WAIT_CYCLES),
        .CNT_W           (CNT_W)
    ) u_fsm (
        .clk           (clk),
        .rst           (rst),
        .mem_op_in_mem (mem_q.valid & mem_q.mem_op),
        .freeze_all    (freeze_all)
    );

    always_comb begin
        id_slot          = '0;
        id_slot.valid    = 1'b1;
        id_slot.dest     = id_dest;
        id_slot.wb_en    = id_wb_en;
        id_slot.mem_read = id_mem_read;
        id_slot.mem_op   = id_mem_read | id_mem_write;
    end

    // WB is deliberately not compared: the register file writes on negedge
    always_comb begin
        hit1_exe = id_src1_used & slot_hit(exe_q, id_src1);
        hit2_exe = id_two_src   & slot_hit(exe_q, id_src2);
        hit1_mem = id_src1_used & slot_hit(mem_q, id_src1);
        hit2_mem = id_two_src   & slot_hit(mem_q, id_src2);
        if (forward_en) begin
            hazard = (hit1_exe | hit2_exe) & exe_q.mem_read;
        end else begin
            hazard = hit1_exe | hit2_exe | hit1_mem | hit2_mem;
        end
    end

    always_comb begin
        flush        = exe_branch_taken & ~freeze_all & ~rst;
        flush_if_id  = flush;
        flush_id_exe = flush;
        hazard_stall = hazard & ~exe_branch_taken & ~freeze_all & ~rst;
    end

    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        if (!freeze_all) begin
            mem_d = exe_q;
            exe_d = (hazard_stall | flush) ? '0 : id_slot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q <= '0;
            mem_q <= '0;
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
        end
    end

endmodule
